// File: rtl/control_sequencer.sv
// Basic-computer timing/control sequencer: run flip-flop, one-hot T from SC, latched opcode decode D/I.
// Latency: start edge -> T0 next cycle; no backpressure, halt/sc_clr act on the next edge.
module control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        sc_clr,
  input  logic [15:0] ir,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic        I,
  output logic        running,
  output logic        seq_err
);

  logic       s;
  logic [2:0] sc;
  logic [2:0] opr;
  logic       ind;
  logic       err;

  // Only the opcode/indirect field is decoded here; the address field belongs to the datapath.
  logic unused_ir;
  assign unused_ir = ^ir[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s   <= 1'b0;
      sc  <= 3'd0;
      opr <= 3'd0;
      ind <= 1'b0;
      err <= 1'b0;
    end else begin
      if (halt)
        s <= 1'b0;
      else if (start && !s)
        s <= 1'b1;

      if (!s || halt || sc_clr)
        sc <= 3'd0;
      else
        sc <= sc + 3'd1;

      if (s && (sc == 3'd7) && !sc_clr && !halt)
        err <= 1'b1;

      // Opcode latches on the T2 edge even if the instruction is cleared or halted there.
      if (s && (sc == 3'd2)) begin
        opr <= ir[14:12];
        ind <= ir[15];
      end
    end
  end

  assign T       = s ? (8'h01 << sc) : 8'h00;
  assign D       = 8'h01 << opr;
  assign I       = ind;
  assign running = s;
  assign seq_err = err;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer against a cycle-level reference model.
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        sc_clr;
  logic [15:0] ir;
  logic [7:0]  T;
  logic [7:0]  D;
  logic        I;
  logic        running;
  logic        seq_err;

  int tests = 0;
  int fails = 0;

  // Reference state, kept as plain integers.
  int m_run = 0;
  int m_step = 0;
  int m_op = 0;
  int m_ind = 0;
  int m_err = 0;

  control_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .halt    (halt),
    .sc_clr  (sc_clr),
    .ir      (ir),
    .T       (T),
    .D       (D),
    .I       (I),
    .running (running),
    .seq_err (seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_run = 0; m_step = 0; m_op = 0; m_ind = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int was_run;
    int was_step;
    if (!rst_n) begin
      model_reset();
    end else begin
      was_run  = m_run;
      was_step = m_step;
      if (was_run != 0 && was_step == 2) begin
        m_op  = int'(ir[14:12]);
        m_ind = int'(ir[15]);
      end
      if (was_run != 0 && was_step == 7 && !sc_clr && !halt) m_err = 1;
      if (was_run == 0 || halt || sc_clr) m_step = 0;
      else m_step = (was_step + 1) % 8;
      if (halt) m_run = 0;
      else if (start) m_run = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_t;
    logic [7:0] exp_d;
    exp_t = (m_run != 0) ? (8'h01 << m_step) : 8'h00;
    exp_d = 8'h01 << m_op;
    tests++;
    assert (T === exp_t) else begin
      fails++; $error("FAIL %s T got %h want %h", tag, T, exp_t);
    end
    tests++;
    assert (D === exp_d) else begin
      fails++; $error("FAIL %s D got %h want %h", tag, D, exp_d);
    end
    tests++;
    assert (I === m_ind[0]) else begin
      fails++; $error("FAIL %s I got %b want %b", tag, I, m_ind[0]);
    end
    tests++;
    assert (running === m_run[0]) else begin
      fails++; $error("FAIL %s running got %b want %b", tag, running, m_run[0]);
    end
    tests++;
    assert (seq_err === m_err[0]) else begin
      fails++; $error("FAIL %s seq_err got %b want %b", tag, seq_err, m_err[0]);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++; $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; sc_clr = 1'b0; ir = 16'h0000;
    #3;
    check_all("reset_async");
    chk8("reset_D", D, 8'h01);
    step("reset_hold");
    step("reset_hold");
    rst_n = 1'b1;

    // Idle after reset
    for (int k = 0; k < 10; k++) begin
      step("idle");
      chk8("idle_T", T, 8'h00);
    end

    // Start and count through all eight T states, then wrap
    start = 1'b1;
    step("start");
    start = 1'b0;
    chk8("count_T0", T, 8'h01);
    for (int k = 1; k < 8; k++) begin
      step("count");
      chk8("count_T", T, 8'h01 << k);
    end
    step("wrap");
    chk8("wrap_T", T, 8'h01);
    chk8("wrap_err", {7'd0, seq_err}, 8'h01);

    // Decode hold across a changed ir
    do_reset();
    ir = 16'hB123;
    start = 1'b1;
    step("dec_T0");
    start = 1'b0;
    step("dec_T1");
    step("dec_T2");
    step("dec_T3");
    chk8("dec_D", D, 8'h08);
    chk8("dec_I", {7'd0, I}, 8'h01);
    step("dec_T4");
    ir = 16'h7000;
    for (int k = 5; k < 8; k++) begin
      step("dec_hold");
      chk8("dec_hold_D", D, 8'h08);
    end
    step("dec2_T0");
    step("dec2_T1");
    step("dec2_T2");
    chk8("dec2_T2_D", D, 8'h08);
    step("dec2_T3");
    chk8("dec2_D", D, 8'h80);
    chk8("dec2_I", {7'd0, I}, 8'h00);

    // Two-instruction loop with sc_clr in T4
    do_reset();
    ir = 16'h2000;
    start = 1'b1;
    step("loop1_T0");
    start = 1'b0;
    step("loop1_T1");
    step("loop1_T2");
    step("loop1_T3");
    chk8("loop1_D", D, 8'h04);
    step("loop1_T4");
    chk8("loop1_T4", T, 8'h10);
    sc_clr = 1'b1;
    step("loop2_T0");
    sc_clr = 1'b0;
    chk8("loop2_T0", T, 8'h01);
    ir = 16'h9000;
    step("loop2_T1");
    step("loop2_T2");
    step("loop2_T3");
    chk8("loop2_D", D, 8'h02);
    chk8("loop2_I", {7'd0, I}, 8'h01);
    step("loop2_T4");
    sc_clr = 1'b1;
    step("loop3_T0");
    sc_clr = 1'b0;
    chk8("loop3_T0", T, 8'h01);
    chk8("loop_err", {7'd0, seq_err}, 8'h00);

    // halt, start and sc_clr together in T5
    for (int k = 1; k < 6; k++) step("pri_run");
    chk8("pri_T5", T, 8'h20);
    halt = 1'b1; start = 1'b1; sc_clr = 1'b1;
    step("pri_halt");
    halt = 1'b0; start = 1'b0; sc_clr = 1'b0;
    chk8("pri_T", T, 8'h00);
    chk8("pri_run", {7'd0, running}, 8'h00);
    step("pri_idle");
    step("pri_idle");
    start = 1'b1;
    step("pri_restart");
    start = 1'b0;
    chk8("pri_restart_T", T, 8'h01);
    chk8("pri_keep_D", D, 8'h02);

    // Async reset between edges during T6
    for (int k = 1; k < 7; k++) step("ar_run");
    chk8("ar_T6", T, 8'h40);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("ar_immediate");
    chk8("ar_T", T, 8'h00);
    chk8("ar_D", D, 8'h01);
    step("ar_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step("ar_idle");
      chk8("ar_idle_T", T, 8'h00);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      ir     = 16'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      halt   = ($urandom_range(0, 19) == 0);
      sc_clr = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_async");
      end
      step("rnd");
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
